// File: rtl/uart_audio_pkg.sv
// Shared types and constants for the UART audio receive path.
package uart_audio_pkg;

  localparam int DEFAULT_BPS          = 24;
  localparam int CLKS_PER_BIT         = 640;
  localparam int TIMEOUT_BITS         = 20;
  localparam int DEFAULT_TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int ERR_COUNT_W          = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2
  } packer_state_t;

  // Saturating increment so the error count sticks at all-ones.
  function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] value);
    return (&value) ? value : value + ERR_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/packer_timeout.sv
// Idle counter that raises expired once LIMIT-1 clocks have passed since the last clear.
module packer_timeout #(
  parameter int LIMIT = 12800
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT - 1));

  // Holds at the limit so a missed clear can never wrap back into range.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_sample_packer.sv
// Packs little-endian UART bytes into BPS-bit samples with timeout resync and overflow flagging.
// Optional trailing XOR checksum byte per sample: define UART_PACKER_CHECKSUM_EN.
module uart_sample_packer
  import uart_audio_pkg::*;
#(
  parameter int BPS          = DEFAULT_BPS,
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic                   in_clk,
  input  logic                   in_reset_n,
  input  logic                   in_uart_ready,
  input  logic [7:0]             in_uart_frame,
  output logic [BPS-1:0]         out_frame,
  output logic                   out_ready,
  input  logic                   in_accept,
  output logic                   out_overflow,
  output logic [ERR_COUNT_W-1:0] out_err_count
);

  localparam int NBYTES = BPS / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  packer_state_t  state;
  logic [CNT_W-1:0] byte_cnt;
  logic [BPS-1:0] sample;
  logic [BPS-1:0] next_sample;
  logic           store;
  logic           last_byte;
  logic           complete;
  logic           csum_fail;
  logic           expired;
  logic           timeout_hit;
  logic           timeout_clear;
`ifdef UART_PACKER_CHECKSUM_EN
  logic [7:0]     csum;
`endif

  assign last_byte     = (byte_cnt == LAST_BYTE);
  assign store         = in_uart_ready && (state == S_IDLE || state == S_COLLECT);
  // A strobe on the expiry cycle takes priority over the timeout.
  assign timeout_hit   = expired && !in_uart_ready && (state != S_IDLE);
  assign timeout_clear = in_uart_ready || (state == S_IDLE) || timeout_hit;

`ifdef UART_PACKER_CHECKSUM_EN
  assign complete  = in_uart_ready && (state == S_CHECK) && (in_uart_frame == csum);
  assign csum_fail = in_uart_ready && (state == S_CHECK) && (in_uart_frame != csum);
`else
  assign complete  = store && last_byte;
  assign csum_fail = 1'b0;
`endif

  always_comb begin
    next_sample = sample;
    for (int k = 0; k < NBYTES; k++) begin
      if (store && byte_cnt == CNT_W'(k)) begin
        next_sample[8*k +: 8] = in_uart_frame;
      end
    end
  end

  packer_timeout #(
    .LIMIT(TIMEOUT_CLKS)
  ) u_timeout (
    .clk    (in_clk),
    .reset_n(in_reset_n),
    .clear  (timeout_clear),
    .expired(expired)
  );

  // Sequencing, checksum tracking, error counting and the output holding register.
  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      sample        <= '0;
      out_frame     <= '0;
      out_ready     <= 1'b0;
      out_overflow  <= 1'b0;
      out_err_count <= '0;
`ifdef UART_PACKER_CHECKSUM_EN
      csum          <= 8'h00;
`endif
    end else begin
      if (timeout_hit) begin
        state    <= S_IDLE;
        byte_cnt <= '0;
      end else if (store) begin
        sample <= next_sample;
        if (last_byte) begin
          byte_cnt <= '0;
`ifdef UART_PACKER_CHECKSUM_EN
          state    <= S_CHECK;
`else
          state    <= S_IDLE;
`endif
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          state    <= S_COLLECT;
        end
      end
`ifdef UART_PACKER_CHECKSUM_EN
      else if (state == S_CHECK && in_uart_ready) begin
        state <= S_IDLE;
      end

      if (store) begin
        csum <= ((state == S_IDLE) ? 8'h00 : csum) ^ in_uart_frame;
      end
`endif

      if (timeout_hit || csum_fail) begin
        out_err_count <= sat_inc(out_err_count);
      end

      // An unaccepted pending sample wins over a newly completed one.
      if (complete) begin
        if (out_ready && !in_accept) begin
          out_overflow <= 1'b1;
        end else begin
          out_frame <= next_sample;
          out_ready <= 1'b1;
        end
      end else if (out_ready && in_accept) begin
        out_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_packer.sv
// Directed bench for uart_sample_packer (BPS=24, short timeout); follows UART_PACKER_CHECKSUM_EN.
module tb_uart_sample_packer;

  localparam int BPS = 24;
  localparam int T   = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           uart_ready = 1'b0;
  logic [7:0]     uart_frame = 8'h00;
  logic [BPS-1:0] frame;
  logic           ready;
  logic           accept = 1'b0;
  logic           overflow;
  logic [7:0]     err_count;

  int checks = 0;
  int errors = 0;

  uart_sample_packer #(
    .BPS(BPS),
    .TIMEOUT_CLKS(T)
  ) dut (
    .in_clk       (clk),
    .in_reset_n   (reset_n),
    .in_uart_ready(uart_ready),
    .in_uart_frame(uart_frame),
    .out_frame    (frame),
    .out_ready    (ready),
    .in_accept    (accept),
    .out_overflow (overflow),
    .out_err_count(err_count)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; callers are always parked on a falling edge.
  task automatic strobe(input logic [7:0] b);
    uart_ready = 1'b1;
    uart_frame = b;
    @(negedge clk);
    uart_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic accept_one();
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
  endtask

  // Sends one sample; acc drives in_accept during the completing strobe.
  task automatic send_sample(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic acc);
    strobe(b0);
    strobe(b1);
`ifdef UART_PACKER_CHECKSUM_EN
    strobe(b2);
    accept = acc;
    strobe(b0 ^ b1 ^ b2);
`else
    accept = acc;
    strobe(b2);
`endif
    accept = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (frame !== 24'h0) begin errors++; $display("[TB] FAIL reset_frame: got %h expected %h", frame, 24'h0); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err: got %0d expected 0", err_count); end
  endtask

  task automatic test_basic();
    send_sample(8'h11, 8'h22, 8'h33, 1'b0);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: got %b expected 1", ready); end
    checks++; if (frame !== 24'h332211) begin errors++; $display("[TB] FAIL basic_frame: got %h expected 332211", frame); end
    idle(5);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_hold_ready: got %b expected 1", ready); end
    checks++; if (frame !== 24'h332211) begin errors++; $display("[TB] FAIL basic_hold_frame: got %h expected 332211", frame); end
  endtask

  task automatic test_overflow();
    send_sample(8'hAA, 8'hBB, 8'hCC, 1'b0);
    checks++; if (frame !== 24'h332211) begin errors++; $display("[TB] FAIL ovf_keep_frame: got %h expected 332211", frame); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    do_reset();
    send_sample(8'h11, 8'h22, 8'h33, 1'b0);
    send_sample(8'hAA, 8'hBB, 8'hCC, 1'b1);
    checks++; if (frame !== 24'hCCBBAA) begin errors++; $display("[TB] FAIL xfer_frame: got %h expected ccbbaa", frame); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL xfer_no_ovf: got %b expected 0", overflow); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL xfer_ready: got %b expected 1", ready); end
    accept_one();
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL accept_clears: got %b expected 0", ready); end
  endtask

  task automatic test_timeout();
    strobe(8'h01);
    strobe(8'h02);
    idle(T - 1);
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL timeout_early: got %0d expected 0", err_count); end
    idle(1);
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL timeout_count: got %0d expected 1", err_count); end
    send_sample(8'h10, 8'h20, 8'h30, 1'b0);
    checks++; if (frame !== 24'h302010) begin errors++; $display("[TB] FAIL resync_frame: got %h expected 302010", frame); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL resync_ready: got %b expected 1", ready); end
    accept_one();
  endtask

  task automatic test_expiry_strobe();
    strobe(8'h01);
    strobe(8'h02);
    idle(T - 1);
    strobe(8'h03);
`ifdef UART_PACKER_CHECKSUM_EN
    strobe(8'h00);
`endif
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL expiry_err: got %0d expected 1", err_count); end
    checks++; if (frame !== 24'h030201) begin errors++; $display("[TB] FAIL expiry_frame: got %h expected 030201", frame); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL expiry_ready: got %b expected 1", ready); end
    accept_one();
  endtask

  task automatic test_reset_mid();
    strobe(8'h05);
    strobe(8'h06);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    checks++; if (frame !== 24'h0) begin errors++; $display("[TB] FAIL mid_reset_frame: got %h expected 0", frame); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 0", ready); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset_err: got %0d expected 0", err_count); end
    send_sample(8'h07, 8'h08, 8'h09, 1'b0);
    checks++; if (frame !== 24'h090807) begin errors++; $display("[TB] FAIL mid_reset_clean: got %h expected 090807", frame); end
    accept_one();
  endtask

`ifdef UART_PACKER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h00);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL csum_good_ready: got %b expected 1", ready); end
    checks++; if (frame !== 24'h332211) begin errors++; $display("[TB] FAIL csum_good_frame: got %h expected 332211", frame); end
    accept_one();
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h01);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL csum_bad_ready: got %b expected 0", ready); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL csum_bad_err: got %0d expected 1", err_count); end
  endtask
`endif

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      strobe(8'h01);
      idle(T);
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_value: got %0d expected 255", err_count); end
    strobe(8'h01);
    idle(T);
    checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 255", err_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_timeout();
    test_expiry_strobe();
    test_reset_mid();
`ifdef UART_PACKER_CHECKSUM_EN
    test_checksum();
`endif
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
